// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 burst memory slave over a DEPTH_WORDS x 32-bit word RAM
// Ports: i_clk, i_rst (sync, active high); s_axi_aw*/s_axi_w*/s_axi_b* write address/data/response;
// s_axi_ar*/s_axi_r* read address/data. Build option AXI_SLV_STALL_EN adds LFSR-driven ready/beat stalls.
module axi_slave_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ID_WIDTH = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];
    logic        stall;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

`ifdef AXI_SLV_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge i_clk)
        if (i_rst) lfsr <= 16'hACE1;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign stall = lfsr[1:0] == 2'b00;
`else
    assign stall = 1'b0;
`endif

    w_state_t            w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [29:0]         w_addr;
    logic [7:0]          w_len, w_cnt;
    logic [1:0]          w_burst;
    logic                w_slverr, w_decerr;
    logic                aw_fire, w_fire, w_end, w_in_range, w_we;

    assign s_axi_awready = w_state == W_IDLE && !stall;
    assign s_axi_wready  = w_state == W_DATA && !stall;
    assign s_axi_bvalid  = w_state == W_RESP;
    assign s_axi_bid     = w_id;
    // DECERR (11) outranks SLVERR (10)
    assign s_axi_bresp   = {w_decerr | w_slverr, w_decerr};
    assign aw_fire       = s_axi_awvalid && s_axi_awready;
    assign w_fire        = s_axi_wvalid && s_axi_wready;
    assign w_end         = w_cnt == w_len;
    assign w_in_range    = w_addr < DEPTH_LIM;
    // a reserved burst type writes nothing; reset cancels any beat in flight
    assign w_we          = w_fire && w_in_range && w_burst != 2'b11 && !i_rst;

    always_ff @(posedge i_clk)
        if (i_rst) w_state <= W_IDLE;
        else w_state <= w_next;

    always_comb begin
        w_next = w_state;
        if (aw_fire) w_next = W_DATA;
        if (w_fire && w_end) w_next = W_RESP;
        if (s_axi_bvalid && s_axi_bready) w_next = W_IDLE;
    end

    always_ff @(posedge i_clk)
        if (i_rst) begin
            w_id     <= '0;
            w_addr   <= '0;
            w_len    <= '0;
            w_burst  <= '0;
            w_cnt    <= '0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else if (aw_fire) begin
            w_id     <= s_axi_awid;
            w_addr   <= s_axi_awaddr[31:2];
            w_len    <= s_axi_awlen;
            w_burst  <= s_axi_awburst;
            w_cnt    <= '0;
            w_slverr <= 1'b0;
            w_decerr <= 1'b0;
        end else if (w_fire) begin
            w_cnt    <= w_cnt + 8'd1;
            w_addr   <= w_addr + 30'(w_burst != 2'b00);
            w_slverr <= w_slverr | (s_axi_wlast != w_end) | (w_burst == 2'b11);
            w_decerr <= w_decerr | !w_in_range;
        end

    always_ff @(posedge i_clk)
        for (int b = 0; b < 4; b++)
            if (w_we && s_axi_wstrb[b]) mem[w_addr[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];

    r_state_t    r_state, r_next;
    logic [29:0] r_addr, ld_addr;
    logic [7:0]  r_len, r_cnt, ld_cnt;
    logic [1:0]  r_burst, ld_burst;
    logic        ar_fire, r_fire, ld_go, ld_in_range;

    assign s_axi_arready = r_state == R_IDLE && !stall;
    assign ar_fire       = s_axi_arvalid && s_axi_arready;
    assign r_fire        = s_axi_rvalid && s_axi_rready;
    // load a beat on AR accept, after a non-last beat is taken, or when a stalled beat is pending
    assign ld_go         = ar_fire || (r_state == R_DATA && (r_fire ? !s_axi_rlast : !s_axi_rvalid));
    assign ld_addr       = r_state == R_IDLE ? s_axi_araddr[31:2] : r_addr;
    assign ld_burst      = r_state == R_IDLE ? s_axi_arburst : r_burst;
    assign ld_cnt        = r_state == R_IDLE ? 8'd0 : r_cnt + 8'd1;
    assign ld_in_range   = ld_addr < DEPTH_LIM;

    always_ff @(posedge i_clk)
        if (i_rst) r_state <= R_IDLE;
        else r_state <= r_next;

    always_comb begin
        r_next = r_state;
        if (ar_fire) r_next = R_DATA;
        if (r_fire && s_axi_rlast) r_next = R_IDLE;
    end

    // the RAM is read in the same cycle it may be written, so a colliding read sees the old word
    always_ff @(posedge i_clk)
        if (i_rst) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= '0;
            s_axi_rid    <= '0;
            r_addr       <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_burst      <= '0;
        end else begin
            if (ar_fire) begin
                s_axi_rid <= s_axi_arid;
                r_len     <= s_axi_arlen;
                r_burst   <= s_axi_arburst;
            end
            if (ld_go && !stall) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= ld_in_range && ld_burst != 2'b11 ? mem[ld_addr[IDX_W-1:0]] : 32'd0;
                s_axi_rresp  <= !ld_in_range ? 2'b11 : ld_burst == 2'b11 ? 2'b10 : 2'b00;
                s_axi_rlast  <= ld_cnt == (r_state == R_IDLE ? s_axi_arlen : r_len);
                r_cnt        <= ld_cnt;
                r_addr       <= ld_addr + 30'(ld_burst != 2'b00);
            end else if (r_fire) begin
                s_axi_rvalid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: self-checking bench for axi_slave_mem against a word-array reference model
module tb_axi_slave_mem;
    localparam int DEPTH = 128;

    logic        clk = 0, rst = 1;
    logic        awid = 0, awvalid = 0, wlast = 0, wvalid = 0, bready = 0;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [1:0]  awburst = 0, arburst = 0;
    logic [3:0]  wstrb = 0;
    logic        arid = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bid, bvalid, arready, rid, rlast, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    axi_slave_mem #(.DEPTH_WORDS(DEPTH), .ID_WIDTH(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] got_d [16];
    logic [1:0]  got_r [16];
    logic        got_l [16];
    logic        got_id, wr_bid;
    logic [1:0]  wr_resp;
    int          got_n, rd_lat, wr_lat;
    bit          rd_stable, rd_done, wr_stable, wr_done;
    logic        rd_post_rvalid, rd_post_arready;

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [1:0]  burst;
        logic        id;
        logic [31:0] d0;
        logic [1:0]  bresp;
        int          stall_beat;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: apply a burst to the word array and return the response AXI rules require
    function automatic logic [1:0] model_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                                               input bit bad_last);
        int  w = int'(addr >> 2);
        bit  dec = 0;
        bit  slv = (burst == 2'b11) || bad_last;
        for (int k = 0; k <= len; k++) begin
            int a = (burst == 2'b00) ? w : w + k;
            if (a >= DEPTH) dec = 1;
            else if (burst != 2'b11)
                for (int by = 0; by < 4; by++)
                    if (ws[k][by]) ref_mem[a][8*by +: 8] = wd[k][8*by +: 8];
        end
        return dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id,
                            input bit bad_last);
        int t = 0, beat = 0, aw_t = -1, b_t = -1;
        bit done = 0, aw_hs, w_hs, b_hs;
        wr_stable = 1;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1;
        wdata = wd[0]; wstrb = ws[0]; wlast = (len == 0) ^ bad_last; wvalid = 1;
        while (!done && t < 400) begin
            if (bvalid) begin
                if (b_t < 0) begin
                    b_t = t; wr_resp = bresp; wr_bid = bid;
                end else if (bresp !== wr_resp || bid !== wr_bid) wr_stable = 0;
            end
            bready = bvalid && b_t >= 0 && t > b_t;
            aw_hs = awvalid && awready;
            w_hs = wvalid && wready;
            b_hs = bvalid && bready;
            step();
            t++;
            if (aw_hs) begin awvalid = 0; aw_t = t - 1; end
            if (w_hs) begin
                beat++;
                if (beat > len) wvalid = 0;
                else begin wdata = wd[beat]; wstrb = ws[beat]; wlast = (beat == len); end
            end
            if (b_hs) begin done = 1; bready = 0; end
        end
        awvalid = 0; wvalid = 0; bready = 0;
        wr_lat = b_t - aw_t;
        wr_done = done;
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id,
                           input int stall_beat, input int stall_n, input bit rnd);
        int t = 0, beat = 0, held = 0, ar_t = -1, f_t = -1;
        bit done = 0, ar_hs, r_hs, have_prev = 0, prev_rr = 0, lst;
        logic [31:0] pd = 0;
        logic [1:0]  pr = 0;
        logic        pl = 0;
        rd_stable = 1;
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1; rready = 0;
        while (!done && t < 400) begin
            if (rvalid) begin
                if (f_t < 0) f_t = t;
                if (have_prev && !prev_rr && (rdata !== pd || rresp !== pr || rlast !== pl)) rd_stable = 0;
                got_d[beat] = rdata; got_r[beat] = rresp; got_l[beat] = rlast; got_id = rid;
                pd = rdata; pr = rresp; pl = rlast;
            end
            rready = rnd ? ($urandom_range(0, 2) != 0) : !(beat == stall_beat && held < stall_n);
            if (rvalid && !rready) held++;
            have_prev = rvalid;
            prev_rr = rready;
            ar_hs = arvalid && arready;
            r_hs = rvalid && rready;
            lst = rlast;
            step();
            t++;
            if (ar_hs) begin arvalid = 0; ar_t = t - 1; end
            if (r_hs) begin
                beat++;
                if (lst || beat >= 16) done = 1;
            end
        end
        arvalid = 0; rready = 0;
        got_n = beat; rd_lat = f_t - ar_t; rd_done = done;
        rd_post_rvalid = rvalid; rd_post_arready = arready;
    endtask

    task automatic wr_cmp(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id,
                          input bit bad_last, input logic [1:0] exp_resp, input string tag);
        do_write(addr, len, burst, id, bad_last);
        chk({tag, " wr_done"}, 32'(wr_done), 1);
        chk({tag, " bresp"}, 32'(wr_resp), 32'(exp_resp));
        chk({tag, " bid"}, 32'(wr_bid), 32'(id));
        chk({tag, " b_stable"}, 32'(wr_stable), 1);
        if (len == 0) chk({tag, " aw_to_b_latency"}, 32'(wr_lat), 2);
    endtask

    task automatic rd_cmp(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic id,
                          input int stall_beat, input int stall_n, input bit rnd, input string tag);
        int w = int'(addr >> 2);
        do_read(addr, len, burst, id, stall_beat, stall_n, rnd);
        chk({tag, " rd_done"}, 32'(rd_done), 1);
        chk({tag, " beats"}, 32'(got_n), 32'(len + 1));
        chk({tag, " rid"}, 32'(got_id), 32'(id));
        chk({tag, " ar_to_r_latency"}, 32'(rd_lat), 1);
        chk({tag, " r_stable"}, 32'(rd_stable), 1);
        chk({tag, " rvalid_after"}, 32'(rd_post_rvalid), 0);
        chk({tag, " arready_after"}, 32'(rd_post_arready), 1);
        for (int k = 0; k <= len && k < got_n; k++) begin
            int a = (burst == 2'b00) ? w : w + k;
            logic [31:0] ed = (a >= DEPTH || burst == 2'b11) ? 32'd0 : ref_mem[a];
            logic [1:0]  er = a >= DEPTH ? 2'b11 : burst == 2'b11 ? 2'b10 : 2'b00;
            chk($sformatf("%s rdata[%0d]", tag, k), got_d[k], ed);
            chk($sformatf("%s rresp[%0d]", tag, k), 32'(got_r[k]), 32'(er));
            chk($sformatf("%s rlast[%0d]", tag, k), 32'(got_l[k]), 32'(k == len));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d0, d1;
        logic [1:0]  b, e;
        int          l;
        bit          bad;
        tbl[0] = '{32'h010, 0,  2'b01, 1'b1, 32'hDEADBEEF, 2'b00, -1};
        tbl[1] = '{32'h100, 15, 2'b01, 1'b0, 32'h0,        2'b00, 5};
        tbl[2] = '{32'h040, 3,  2'b00, 1'b1, 32'hA,        2'b00, -1};
        tbl[3] = '{32'h1FC, 1,  2'b01, 1'b0, 32'h5000,     2'b11, -1};
        tbl[4] = '{32'h080, 2,  2'b11, 1'b1, 32'h6000,     2'b10, -1};
        tbl[5] = '{32'h0C0, 3,  2'b10, 1'b0, 32'h7000,     2'b00, -1};
        tbl[6] = '{32'h200, 0,  2'b01, 1'b1, 32'h8000,     2'b11, -1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst awready", 32'(awready), 1);
        chk("rst arready", 32'(arready), 1);
        chk("rst wready", 32'(wready), 0);
        chk("rst bvalid", 32'(bvalid), 0);
        chk("rst rvalid", 32'(rvalid), 0);
        chk("rst rlast", 32'(rlast), 0);
        chk("rst bresp", 32'(bresp), 0);
        chk("rst rresp", 32'(rresp), 0);
        chk("rst rdata", rdata, 0);
        chk("rst bid", 32'(bid), 0);
        chk("rst rid", 32'(rid), 0);
        for (int p = 0; p < DEPTH / 16; p++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
            e = model_write(32'(p * 64), 15, 2'b01, 0);
            wr_cmp(32'(p * 64), 15, 2'b01, 1'b0, 0, e, $sformatf("preload%0d", p));
        end
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 16; k++) begin wd[k] = tbl[i].d0 + 32'(k); ws[k] = 4'hF; end
            void'(model_write(tbl[i].addr, tbl[i].len, tbl[i].burst, 0));
            wr_cmp(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].id, 0, tbl[i].bresp, $sformatf("tbl%0d", i));
            rd_cmp(tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].id, tbl[i].stall_beat, 3, 0,
                   $sformatf("tbl%0d", i));
            if (i == 0) chk("single rdata", got_d[0], 32'hDEADBEEF);
            if (i == 2) chk("fixed last wins", got_d[0], 32'hD);
        end
        rd_cmp(32'h44, 0, 2'b01, 1'b0, -1, 0, 0, "fixed neighbour");
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        void'(model_write(32'h20, 0, 2'b01, 0));
        wr_cmp(32'h20, 0, 2'b01, 1'b0, 0, 2'b00, "strb base");
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        void'(model_write(32'h20, 0, 2'b01, 0));
        wr_cmp(32'h20, 0, 2'b01, 1'b1, 0, 2'b00, "strb merge");
        rd_cmp(32'h20, 0, 2'b01, 1'b1, -1, 0, 0, "strb read");
        chk("strb merged word", got_d[0], 32'h11BB33DD);
        for (int k = 0; k < 2; k++) begin wd[k] = 32'hB00 + 32'(k); ws[k] = 4'hF; end
        void'(model_write(32'h60, 1, 2'b01, 1));
        wr_cmp(32'h60, 1, 2'b01, 1'b0, 1, 2'b10, "bad wlast");
        rd_cmp(32'h60, 1, 2'b01, 1'b0, -1, 0, 0, "bad wlast read");
        d0 = $urandom; d1 = $urandom;
        awid = 0; awaddr = 32'h180; awlen = 7; awburst = 2'b01; awvalid = 1;
        wdata = d0; wstrb = 4'hF; wlast = 0; wvalid = 1;
        step();
        awvalid = 0;
        step();
        wdata = d1;
        step();
        wvalid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("midrst awready", 32'(awready), 1);
        chk("midrst wready", 32'(wready), 0);
        chk("midrst bvalid", 32'(bvalid), 0);
        ref_mem[96] = d0;
        ref_mem[97] = d1;
        rd_cmp(32'h180, 3, 2'b01, 1'b1, -1, 0, 0, "midrst persist");
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        void'(model_write(32'h180, 3, 2'b01, 0));
        wr_cmp(32'h180, 3, 2'b01, 1'b1, 0, 2'b00, "post rst write");
        rd_cmp(32'h180, 3, 2'b01, 1'b0, -1, 0, 1, "post rst read");
        for (int i = 0; i < 30; i++) begin
            a = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'($urandom_range(0, 3));
            l = $urandom_range(0, 15);
            b = 2'($urandom_range(0, 3));
            bad = $urandom_range(0, 7) == 0;
            for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
            e = model_write(a, l, b, bad);
            wr_cmp(a, l, b, 1'($urandom_range(0, 1)), bad, e, $sformatf("rnd_wr%0d", i));
            a = 32'($urandom_range(0, DEPTH + 3)) * 4;
            rd_cmp(a, $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, 0, 1,
                   $sformatf("rnd_rd%0d", i));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
